// File: rtl/debouncer.sv
// Debouncer: synchronises a raw input and only changes z after N_STABLE identical samples.
// Define DEBOUNCER_SYNC2_EN to insert a second synchroniser flop for asynchronous pins.
module debouncer #(
    parameter int N_STABLE = 4,
    parameter int CNT_W    = 8
) (
    input  logic clock,
    input  logic reset_,
    input  logic x,
    output logic z,
    output logic z_rise,
    output logic z_fall,
    output logic stable
);

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STABLE - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_xs;

    generate
        if (N_STABLE < 2 || N_STABLE > (2 ** CNT_W) - 1) begin : g_bad_n_stable
            $error("debouncer: N_STABLE=%0d out of range for CNT_W=%0d", N_STABLE, CNT_W);
        end
    endgenerate

`ifdef DEBOUNCER_SYNC2_EN
    logic r_s1;

    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_s1 <= 1'b0;
            r_xs <= 1'b0;
        end else begin
            r_s1 <= x;
            r_xs <= r_s1;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_xs <= 1'b0;
        end else begin
            r_xs <= x;
        end
    end
`endif

    // Strobes default low every cycle so each commit yields exactly one pulse.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            z       <= 1'b0;
            z_rise  <= 1'b0;
            z_fall  <= 1'b0;
            stable  <= 1'b1;
        end else begin
            z_rise <= 1'b0;
            z_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (r_xs) begin
                        r_state <= S_WAIT_HIGH;
                        r_cnt   <= CNT_W'(1);
                        stable  <= 1'b0;
                    end else begin
                        r_cnt  <= '0;
                        stable <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!r_xs) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        stable  <= 1'b1;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        z       <= 1'b1;
                        z_rise  <= 1'b1;
                        stable  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!r_xs) begin
                        r_state <= S_WAIT_LOW;
                        r_cnt   <= CNT_W'(1);
                        stable  <= 1'b0;
                    end else begin
                        r_cnt  <= '0;
                        stable <= 1'b1;
                    end
                end
                S_WAIT_LOW: begin
                    if (r_xs) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        stable  <= 1'b1;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        z       <= 1'b0;
                        z_fall  <= 1'b1;
                        stable  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                    z       <= 1'b0;
                    stable  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: a run-length reference pushes expected outputs per edge,
// which are popped and compared after the edge; directed latency checks cover the timing cases.
module tb_debouncer;

    localparam int N_STABLE = 4;
    localparam int CNT_W    = 8;
`ifdef DEBOUNCER_SYNC2_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

    logic clock;
    logic reset_;
    logic x;
    logic z;
    logic z_rise;
    logic z_fall;
    logic stable;

    typedef struct packed {
        logic z;
        logic rise;
        logic fall;
        logic stable;
    } exp_t;

    exp_t expQ[$];

    int compared;
    int mismatched;

    logic mXs;
    logic mS1;
    logic mZ;
    int   mRun;

    debouncer #(
        .N_STABLE(N_STABLE),
        .CNT_W   (CNT_W)
    ) dut (
        .clock (clock),
        .reset_(reset_),
        .x     (x),
        .z     (z),
        .z_rise(z_rise),
        .z_fall(z_fall),
        .stable(stable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pop the oldest expectation and compare every output against it.
    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = expQ.pop_front();
            compared++;
            assert (z === e.z) else begin
                mismatched++;
                $error("FAIL z observed=%0b expected=%0b t=%0t", z, e.z, $time);
            end
            compared++;
            assert (z_rise === e.rise) else begin
                mismatched++;
                $error("FAIL z_rise observed=%0b expected=%0b t=%0t", z_rise, e.rise, $time);
            end
            compared++;
            assert (z_fall === e.fall) else begin
                mismatched++;
                $error("FAIL z_fall observed=%0b expected=%0b t=%0t", z_fall, e.fall, $time);
            end
            compared++;
            assert (stable === e.stable) else begin
                mismatched++;
                $error("FAIL stable observed=%0b expected=%0b t=%0t", stable, e.stable, $time);
            end
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then check after the edge.
    task automatic applyStimulus(input logic xIn, input logic rIn);
        exp_t e;
        logic sample;
        x      = xIn;
        reset_ = rIn;
        e      = '0;
        if (!rIn) begin
            mZ   = 1'b0;
            mRun = 0;
            mXs  = 1'b0;
            mS1  = 1'b0;
            e    = '{z: 1'b0, rise: 1'b0, fall: 1'b0, stable: 1'b1};
        end else begin
            sample = mXs;
            if (sample != mZ) begin
                mRun++;
                if (mRun == N_STABLE) begin
                    mZ       = sample;
                    e.rise   = sample;
                    e.fall   = ~sample;
                    e.stable = 1'b1;
                    mRun     = 0;
                end else begin
                    e.stable = 1'b0;
                end
            end else begin
                mRun     = 0;
                e.stable = 1'b1;
            end
            e.z = mZ;
            if (SYNC_STAGES == 2) begin
                mXs = mS1;
                mS1 = xIn;
            end else begin
                mXs = xIn;
            end
        end
        expQ.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    // Hold x at a level and count edges until the wanted strobe appears (bounded).
    task automatic measureLatency(input logic xIn, input string tag);
        int lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            applyStimulus(xIn, 1'b1);
            lat++;
            seen = xIn ? z_rise : z_fall;
        end
        compared++;
        assert (lat == N_STABLE + SYNC_STAGES && seen) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, lat, N_STABLE + SYNC_STAGES);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        mXs = 1'b0; mS1 = 1'b0; mZ = 1'b0; mRun = 0;
        x      = 1'b1;
        reset_ = 1'b0;
        #2;

        // Reset held for two edges with x high.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);

        // Clean rise, then confirm the strobe lasts a single cycle.
        measureLatency(1'b1, "rise_latency");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);

        // Low glitch one sample shorter than the threshold: no fall.
        for (int i = 0; i < N_STABLE - 1; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1);

        // Clean fall.
        measureLatency(1'b0, "fall_latency");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);

        // High glitch of length one and of length N_STABLE-1.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < N_STABLE - 1; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);

        // Reset while a rise is being timed discards it; retiming starts after release.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        measureLatency(1'b1, "rise_after_reset");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1);

        // Random bounce with short and long runs.
        for (int i = 0; i < 300; i++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, N_STABLE + 2);
            for (int j = 0; j < len; j++) applyStimulus(lvl, 1'b1);
        end

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
